// File: rtl/definitions_pkg.sv
// rtl/definitions_pkg.sv - strength encoding, FSM states and default image size
// for the hysteresis tracker.
package definitions_pkg;

  localparam int DEF_IMG_W = 640;
  localparam int DEF_IMG_H = 480;

  typedef enum logic [1:0] {
    STR_NONE   = 2'b00,
    STR_WEAK   = 2'b01,
    STR_STRONG = 2'b10
  } strength_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACTIVE = 2'b01,
    ST_FLUSH  = 2'b10
  } tracker_state_t;

  function automatic logic is_strong(input logic [1:0] s);
    return s == STR_STRONG;
  endfunction

endpackage

// File: rtl/hyst_line_buffer.sv
// rtl/hyst_line_buffer.sv - one-row delay line: one write port, one
// asynchronous read port, storage deliberately left unreset.
module hyst_line_buffer #(
  parameter int DEPTH = 640,
  parameter int WIDTH = 2
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/hysteresis_tracker.sv
// rtl/hysteresis_tracker.sv - 3x3 hysteresis edge tracking over a raster
// stream of weak/strong classified pixels, with a flush phase per frame.
module hysteresis_tracker
  import definitions_pkg::*;
#(
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] strength,
  input  logic       str_valid,
  output logic       in_ready,
  // "edge" is a reserved word, hence edge_det for the decision output
  output logic       edge_det,
  output logic       edge_valid,
  output logic       frame_done,
  output logic       overflow
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam int FL_W  = $clog2(IMG_W + 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [FL_W-1:0]  FL_LAST  = FL_W'(IMG_W);

  tracker_state_t   state;
  logic [COL_W-1:0] col, cen_col;
  logic [ROW_W-1:0] row, cen_row;
  logic [FL_W-1:0]  fl_cnt;
  logic             accept, flushing, advance, emit;
  logic [1:0]       pin, lb1_rd, lb2_rd;
  logic [1:0]       lcol [3];
  logic [1:0]       mcol [3];
  logic [1:0]       ncol [3];
  logic             top_ok, bot_ok, l_ok, r_ok, nb_strong, decision;

  assign flushing = (state == ST_FLUSH);
  assign accept   = str_valid && in_ready;
  assign advance  = accept || flushing;
  // centre index = input index - IMG_W - 1, so the first decision waits for (1,1)
  assign emit     = flushing ||
                    (accept && ((row > ROW_W'(1)) || (row == ROW_W'(1) && col != '0)));
  assign pin      = (flushing || strength == 2'b11) ? STR_NONE : strength;

  hyst_line_buffer #(.DEPTH(IMG_W), .WIDTH(2)) u_lb1 (
    .clk(clk), .we(advance), .waddr(col), .wdata(pin), .raddr(col), .rdata(lb1_rd)
  );

  hyst_line_buffer #(.DEPTH(IMG_W), .WIDTH(2)) u_lb2 (
    .clk(clk), .we(advance), .waddr(col), .wdata(lb1_rd), .raddr(col), .rdata(lb2_rd)
  );

  assign ncol[0] = lb2_rd;
  assign ncol[1] = lb1_rd;
  assign ncol[2] = pin;

  // Masks come from the centre position, which hides stale buffer/window data
  assign top_ok = (cen_row != '0);
  assign bot_ok = (cen_row != ROW_LAST);
  assign l_ok   = (cen_col != '0);
  assign r_ok   = (cen_col != COL_LAST);

  assign nb_strong =
      (top_ok && ((l_ok && is_strong(lcol[0])) || is_strong(mcol[0]) || (r_ok && is_strong(ncol[0])))) ||
      (l_ok && is_strong(lcol[1])) || (r_ok && is_strong(ncol[1])) ||
      (bot_ok && ((l_ok && is_strong(lcol[2])) || is_strong(mcol[2]) || (r_ok && is_strong(ncol[2]))));

  assign decision = is_strong(mcol[1]) || (mcol[1] == STR_WEAK && nb_strong);

  always_ff @(posedge clk) begin
    if (advance) begin
      lcol[0] <= mcol[0];
      lcol[1] <= mcol[1];
      lcol[2] <= mcol[2];
      mcol[0] <= ncol[0];
      mcol[1] <= ncol[1];
      mcol[2] <= ncol[2];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      col        <= '0;
      row        <= '0;
      cen_col    <= '0;
      cen_row    <= '0;
      fl_cnt     <= '0;
      in_ready   <= 1'b1;
      edge_det   <= 1'b0;
      edge_valid <= 1'b0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      edge_valid <= emit;
      edge_det   <= emit && decision;
      frame_done <= flushing && (fl_cnt == FL_LAST);
      if (str_valid && !in_ready) overflow <= 1'b1;

      if (emit) begin
        cen_col <= (cen_col == COL_LAST) ? '0 : cen_col + 1'b1;
        if (cen_col == COL_LAST) cen_row <= (cen_row == ROW_LAST) ? '0 : cen_row + 1'b1;
      end

      if (advance) col <= (col == COL_LAST) ? '0 : col + 1'b1;
      if (accept && col == COL_LAST) row <= (row == ROW_LAST) ? '0 : row + 1'b1;

      case (state)
        ST_IDLE: begin
          if (accept) state <= ST_ACTIVE;
        end
        ST_ACTIVE: begin
          if (accept && row == ROW_LAST && col == COL_LAST) begin
            state    <= ST_FLUSH;
            in_ready <= 1'b0;
            fl_cnt   <= '0;
          end
        end
        ST_FLUSH: begin
          fl_cnt <= fl_cnt + 1'b1;
          if (fl_cnt == FL_LAST) begin
            state    <= ST_IDLE;
            in_ready <= 1'b1;
            col      <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hysteresis_tracker.sv
// tb/tb_hysteresis_tracker.sv - directed 4x4 frames with hand-computed edge
// masks, overflow during flush and mid-frame reset.
module tb_hysteresis_tracker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] strength;
  logic       str_valid;
  logic       in_ready, edge_det, edge_valid, frame_done, overflow;

  int checks = 0;
  int failures = 0;

  logic [1:0] pix [16];
  bit         out_q [$];
  bit         done_q [$];
  int         ncyc = 0;
  int         first_acc = -1;
  int         first_out = -1;

  hysteresis_tracker #(.IMG_W(4), .IMG_H(4)) dut (
    .clk(clk), .rst_n(rst_n), .strength(strength), .str_valid(str_valid),
    .in_ready(in_ready), .edge_det(edge_det), .edge_valid(edge_valid),
    .frame_done(frame_done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    ncyc = ncyc + 1;
    if (str_valid && in_ready && first_acc < 0) first_acc = ncyc;
    if (edge_valid) begin
      out_q.push_back(edge_det);
      done_q.push_back(frame_done);
      if (first_out < 0) first_out = ncyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_pix();
    for (int i = 0; i < 16; i++) pix[i] = 2'b00;
  endtask

  task automatic start_capture();
    out_q.delete();
    done_q.delete();
    first_acc = -1;
    first_out = -1;
  endtask

  task automatic send_pixels(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      str_valid = 1'b1;
      strength  = pix[i];
    end
    @(posedge clk); #1;
    str_valid = 1'b0;
    strength  = 2'b00;
  endtask

  task automatic analyze(input string tag, input logic [15:0] exp_mask);
    logic [15:0] mask, dmask;
    mask  = '0;
    dmask = '0;
    for (int i = 0; i < out_q.size() && i < 16; i++) begin
      mask[i]  = out_q[i];
      dmask[i] = done_q[i];
    end
    check({tag, "_count"}, out_q.size(), 16);
    check({tag, "_mask"}, {16'h0, mask}, {16'h0, exp_mask});
    check({tag, "_done"}, {16'h0, dmask}, 32'h8000);
  endtask

  initial begin
    rst_n     = 1'b0;
    strength  = 2'b00;
    str_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_edge_valid", edge_valid, 0);
    check("rst_edge", edge_det, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_overflow", overflow, 0);
    rst_n = 1'b1;

    // all strong: every pixel an edge, first output 6 cycles after first accept
    for (int i = 0; i < 16; i++) pix[i] = 2'b10;
    start_capture();
    send_pixels(16);
    repeat (12) @(posedge clk); #1;
    analyze("all_strong", 16'hFFFF);
    check("latency", first_out - first_acc, 6);
    check("idle_in_ready", in_ready, 1);

    // (0,0) strong, (1,1) weak
    clear_pix();
    pix[0] = 2'b10;
    pix[5] = 2'b01;
    start_capture();
    send_pixels(16);
    repeat (12) @(posedge clk); #1;
    analyze("diag_weak", 16'h0021);

    // isolated weak pixel
    clear_pix();
    pix[10] = 2'b01;
    start_capture();
    send_pixels(16);
    repeat (12) @(posedge clk); #1;
    analyze("lone_weak", 16'h0000);

    // strong at right edge of row 0, weak at left edge of row 1: no wrap
    clear_pix();
    pix[3] = 2'b10;
    pix[4] = 2'b01;
    start_capture();
    send_pixels(16);
    repeat (12) @(posedge clk); #1;
    analyze("no_wrap", 16'h0008);

    // mixed pattern with 2'b11 as none, plus input pushed during flush
    clear_pix();
    pix[0]  = 2'b01;
    pix[1]  = 2'b11;
    pix[7]  = 2'b01;
    pix[8]  = 2'b10;
    pix[10] = 2'b01;
    pix[12] = 2'b01;
    pix[15] = 2'b10;
    start_capture();
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      str_valid = 1'b1;
      strength  = pix[i];
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      str_valid = 1'b1;
      strength  = 2'b10;
      check("flush_in_ready", in_ready, 0);
    end
    @(posedge clk); #1;
    str_valid = 1'b0;
    strength  = 2'b00;
    check("overflow_set", overflow, 1);
    repeat (12) @(posedge clk); #1;
    analyze("flush_drop", 16'h9500);
    check("overflow_sticky", overflow, 1);

    // abort a frame after 7 pixels with an asynchronous reset
    for (int i = 0; i < 16; i++) pix[i] = 2'b10;
    send_pixels(7);
    rst_n = 1'b0;
    #2;
    check("abort_in_ready", in_ready, 1);
    check("abort_edge_valid", edge_valid, 0);
    check("abort_overflow", overflow, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    clear_pix();
    pix[0] = 2'b10;
    pix[5] = 2'b01;
    start_capture();
    send_pixels(16);
    repeat (12) @(posedge clk); #1;
    analyze("after_reset", 16'h0021);
    check("after_reset_overflow", overflow, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
